// File: rtl/sdrio_pkg.sv
// Shared definitions for the SDR/DDR-PHY output serializers.
package sdrio_pkg;

    localparam logic OEN_DISABLED = 1'b1;

    function automatic bit ratio_legal(input int ratio);
        return (ratio == 2) || (ratio == 4) || (ratio == 8);
    endfunction

    function automatic int cnt_width(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/sdrio_oser_lane.sv
// One serializer lane: captures a RATIO-bit word on the update edge and rotates it out LSB-first.
module sdrio_oser_lane #(
    parameter int               RATIO      = 4,
    parameter logic [RATIO-1:0] RESET_WORD = '0,
    parameter logic [RATIO-1:0] IDLE_WORD  = '0
) (
    input  logic             geclk_ol,
    input  logic             rst,
    input  logic             capture,
    input  logic             en,
    input  logic [RATIO-1:0] word,
    output logic             q
);

    logic [RATIO-1:0] sreg_d;
    logic [RATIO-1:0] sreg_q;

    // Rotating rather than shifting in zeros keeps the pattern intact while the word boundary is held by a bitslip.
    always_comb begin
        sreg_d = {sreg_q[0], sreg_q[RATIO-1:1]};
        if (capture) begin
            sreg_d = en ? word : IDLE_WORD;
        end
    end

    always_ff @(posedge geclk_ol or posedge rst) begin
        if (rst) begin
            sreg_q <= RESET_WORD;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign q = sreg_q[0];

endmodule

// File: rtl/sdrio_oser_xn.sv
// N:1 output serializer for a group of DQ lanes plus a shared output-enable lane,
// with align restart, runtime bitslip and idle-word substitution.
module sdrio_oser_xn
    import sdrio_pkg::*;
#(
    parameter int   LANES     = 8,
    parameter int   RATIO     = 4,
    parameter int   UPD_PHASE = 2,
    parameter logic IDLE_T    = 1'b1
) (
    input  logic                          geclk_ol,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          align_ol,
    input  logic                          bitslip,
    input  logic [LANES*RATIO-1:0]        d,
    input  logic [RATIO-1:0]              t,
    output logic [LANES-1:0]              q_d,
    output logic                          q_t,
    output logic                          upd,
    output logic [cnt_width(RATIO)-1:0]   slip_cnt
);

    localparam int CNT_W = cnt_width(RATIO);

    if (!ratio_legal(RATIO) || (UPD_PHASE < 0) || (UPD_PHASE >= RATIO)) begin : g_param_check
        $error("sdrio_oser_xn: RATIO must be 2/4/8 and UPD_PHASE must be 0..RATIO-1");
    end

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] slip_cnt_d;
    logic [CNT_W-1:0] slip_cnt_q;
    logic             upd_d;
    logic             upd_q;
    logic             capture;

    // Align overrides bitslip; a bitslip only freezes the counter, so capture on the current cycle is unaffected.
    always_comb begin
        capture    = (cnt_q == CNT_W'(UPD_PHASE));
        upd_d      = capture;
        cnt_d      = (cnt_q == CNT_W'(RATIO - 1)) ? '0 : cnt_q + CNT_W'(1);
        slip_cnt_d = slip_cnt_q;
        if (align_ol) begin
            cnt_d      = '0;
            slip_cnt_d = '0;
        end else if (bitslip) begin
            cnt_d      = cnt_q;
            slip_cnt_d = slip_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge geclk_ol or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            slip_cnt_q <= '0;
            upd_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            slip_cnt_q <= slip_cnt_d;
            upd_q      <= upd_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_data_lane
        sdrio_oser_lane #(
            .RATIO      (RATIO),
            .RESET_WORD ('0),
            .IDLE_WORD  ('0)
        ) u_lane (
            .geclk_ol (geclk_ol),
            .rst      (rst),
            .capture  (capture),
            .en       (en),
            .word     (d[k*RATIO +: RATIO]),
            .q        (q_d[k])
        );
    end

    sdrio_oser_lane #(
        .RATIO      (RATIO),
        .RESET_WORD ({RATIO{OEN_DISABLED}}),
        .IDLE_WORD  ({RATIO{IDLE_T}})
    ) u_oen_lane (
        .geclk_ol (geclk_ol),
        .rst      (rst),
        .capture  (capture),
        .en       (en),
        .word     (t),
        .q        (q_t)
    );

    assign upd      = upd_q;
    assign slip_cnt = slip_cnt_q;

endmodule
